// File: rtl/tick_gen_pkg.sv
// Shared timing constants for the decade strobe generator and its counters.
// Holds the decade ladder, the default clock rate and the prescaler width helper.
package tick_gen_pkg;

    localparam int unsigned CLK_HZ_DEFAULT = 20_000_000;
    localparam int unsigned NUM_DECADES    = 6;
    localparam logic [3:0]  DECADE_TC      = 4'd9;

    // Microseconds per strobe period, fastest (u1clk) to slowest (s1clk).
    localparam int unsigned US_PER_TICK [0:NUM_DECADES] =
        '{1, 10, 100, 1_000, 10_000, 100_000, 1_000_000};

    // A divide-by-one prescaler still needs a 1-bit register.
    function automatic int unsigned pre_width(input int unsigned pre_div);
        return (pre_div > 1) ? $clog2(pre_div) : 1;
    endfunction

endpackage

// File: rtl/decade_cnt.sv
// One 0..9 stage of the decade chain; advances when the faster stage wraps.
// tc_out is combinational so a whole chain can roll over on a single edge.
module decade_cnt
    import tick_gen_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       halt,
    input  logic       en_in,
    output logic       tc_out,
    output logic [3:0] count
);

    logic adv;

    assign adv    = en_in && !halt;
    assign tc_out = adv && (count == DECADE_TC);

    // NOTE: state registers use non-blocking assignments and a synchronous reset,
    // so every counter in the chain samples the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            count <= 4'd0;
        end else if (adv) begin
            // An upset value above 9 falls back to 0 instead of counting on.
            count <= (count >= DECADE_TC) ? 4'd0 : count + 4'd1;
        end
    end

endmodule

// File: rtl/tick_gen.sv
// Free-running timebase: a 1 us prescaler feeding six decade stages, producing
// registered, phase-aligned one-cycle strobes from 1 us up to 1 s.
module tick_gen
    import tick_gen_pkg::*;
#(
    parameter int unsigned CLK_HZ = CLK_HZ_DEFAULT
) (
    input  logic clk,
    input  logic rstn,
    input  logic halt,
    output logic u1clk,
    output logic u10clk,
    output logic u100clk,
    output logic m1clk,
    output logic m10clk,
    output logic m100clk,
    output logic s1clk
);

    localparam int unsigned    PRE_DIV = CLK_HZ / US_PER_TICK[NUM_DECADES];
    localparam int unsigned    PRE_W   = pre_width(PRE_DIV);
    localparam logic [PRE_W-1:0] PRE_TC = PRE_W'(PRE_DIV - 1);

    logic [PRE_W-1:0]            pre;
    logic [NUM_DECADES:0]        tc;
    logic [NUM_DECADES:0]        strobe;
    logic [NUM_DECADES-1:0][3:0] dcount;
    logic [NUM_DECADES*4-1:0]    unused_counts;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pre <= '0;
        end else if (!halt) begin
            pre <= (pre >= PRE_TC) ? '0 : pre + 1'b1;
        end
    end

    // Gating tc[0] with halt freezes the whole chain and blanks every strobe.
    assign tc[0] = !halt && (pre == PRE_TC);

    for (genvar k = 0; k < NUM_DECADES; k++) begin : g_decade
        decade_cnt u_cnt (
            .clk    (clk),
            .rstn   (rstn),
            .halt   (halt),
            .en_in  (tc[k]),
            .tc_out (tc[k+1]),
            .count  (dcount[k])
        );
    end

    // Stage counts are internal state only; the chain exposes just its tc signals.
    assign unused_counts = dcount;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            strobe <= '0;
        end else begin
            strobe <= tc;
        end
    end

    assign u1clk   = strobe[0];
    assign u10clk  = strobe[1];
    assign u100clk = strobe[2];
    assign m1clk   = strobe[3];
    assign m10clk  = strobe[4];
    assign m100clk = strobe[5];
    assign s1clk   = strobe[6];

endmodule

// File: tb/tb_tick_gen.sv
// Scoreboard bench for tick_gen: two instances (PRE_DIV=2 and PRE_DIV=1) share
// rstn/halt; a run-edge counter predicts every strobe from its period arithmetic.
module tb_tick_gen;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    logic halt = 1'b0;

    logic [6:0] out_a;
    logic [6:0] out_b;

    int checks = 0;
    int errors = 0;

    logic [6:0] q_a [$];
    logic [6:0] q_b [$];

    tick_gen #(.CLK_HZ(2_000_000)) dut_a (
        .clk     (clk),
        .rstn    (rstn),
        .halt    (halt),
        .u1clk   (out_a[0]),
        .u10clk  (out_a[1]),
        .u100clk (out_a[2]),
        .m1clk   (out_a[3]),
        .m10clk  (out_a[4]),
        .m100clk (out_a[5]),
        .s1clk   (out_a[6])
    );

    tick_gen #(.CLK_HZ(1_000_000)) dut_b (
        .clk     (clk),
        .rstn    (rstn),
        .halt    (halt),
        .u1clk   (out_b[0]),
        .u10clk  (out_b[1]),
        .u100clk (out_b[2]),
        .m1clk   (out_b[3]),
        .m10clk  (out_b[4]),
        .m100clk (out_b[5]),
        .s1clk   (out_b[6])
    );

    always #5 clk = ~clk;

    // Strobe k fires after the n-th counted edge exactly when n is a multiple of
    // its period PRE_DIV * 10^k.
    function automatic logic [6:0] expect_vec(input longint n, input longint pre_div);
        logic [6:0] v;
        longint     period;
        v      = '0;
        period = pre_div;
        for (int k = 0; k < 7; k++) begin
            v[k]   = (n % period) == 0;
            period = period * 10;
        end
        return v;
    endfunction

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 25)
                $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    // Reference model: counts edges that actually advance the timebase.
    longint run_n = 0;
    initial forever begin
        @(posedge clk);
        if (!rstn) begin
            run_n = 0;
            q_a.push_back(7'b0);
            q_b.push_back(7'b0);
        end else if (halt) begin
            q_a.push_back(7'b0);
            q_b.push_back(7'b0);
        end else begin
            run_n++;
            q_a.push_back(expect_vec(run_n, 2));
            q_b.push_back(expect_vec(run_n, 1));
        end
    end

    // Monitor: compares on the falling edge, away from output updates.
    logic prev_u1_a = 1'b0;
    initial forever begin
        logic [6:0] exp;
        @(negedge clk);
        if (q_a.size() > 0) begin
            exp = q_a.pop_front();
            check("dut_a strobes", out_a, exp);
            check("dut_a alignment", out_a & ~{out_a[5:0], 1'b1}, 7'b0);
            check("dut_a u1clk back-to-back", {6'b0, prev_u1_a & out_a[0]}, 7'b0);
            prev_u1_a = out_a[0];
        end
        if (q_b.size() > 0) begin
            exp = q_b.pop_front();
            check("dut_b strobes", out_b, exp);
            check("dut_b alignment", out_b & ~{out_b[5:0], 1'b1}, 7'b0);
        end
    end

    task automatic drive(input int n, input logic r, input logic h);
        repeat (n) begin
            @(negedge clk);
            rstn = r;
            halt = h;
        end
    endtask

    initial begin
        drive(5, 1'b0, 1'b0);
        // Halt mid-period for 37 cycles, then run through several u10 periods.
        drive(149, 1'b1, 1'b0);
        drive(37, 1'b1, 1'b1);
        drive(300, 1'b1, 1'b0);
        // One-cycle reset mid-period discards the partial count.
        drive(1, 1'b0, 1'b0);
        drive(14, 1'b1, 1'b0);
        drive(1, 1'b0, 1'b0);
        drive(100, 1'b1, 1'b0);
        // Halt and reset together: reset wins.
        drive(3, 1'b0, 1'b1);
        drive(120, 1'b1, 1'b0);
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 3))
                0: drive(int'($urandom_range(1, 400)), 1'b1, 1'b0);
                1: drive(int'($urandom_range(1, 50)), 1'b1, 1'b1);
                2: drive(int'($urandom_range(1, 3)), 1'b0, 1'b0);
                default: drive(int'($urandom_range(1, 3)), 1'b0, 1'b1);
            endcase
            drive(int'($urandom_range(1, 60)), 1'b1, 1'b0);
        end
        // Long run reaches m10clk on both instances and m100clk on none.
        drive(45_000, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
